// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display blocks.
// Segment codes are active-low {a,b,c,d,e,f,g,dp}; dp is always off.
package disp_pkg;

  localparam int DIGITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  // Index of the most significant nonzero nibble; 0 when the word is zero.
  function automatic logic [2:0] topNibble(input logic [31:0] value);
    logic [2:0] top;
    top = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (value[i*4 +: 4] != 4'h0) top = 3'(i);
    end
    return top;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment code, with a blank override.
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : SEG[i_nibble];

endmodule

// File: rtl/hex_result_display.sv
// Eight-digit hex scanner for the calculator result with frame-aligned updates
// and optional leading-zero blanking.
module hex_result_display
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic        load,
  input  logic        blank_lz,
  output logic [7:0]  led_en,
  output logic [7:0]  led_seg,
  output logic        upd
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_idx;
  logic [31:0]      r_hold;
  logic [31:0]      r_shadow;
  logic             r_pending;
  logic             r_updPre;

  logic             w_divEnd;
  logic             w_frameEnd;
  logic [3:0]       w_nibble;
  logic [2:0]       w_top;
  logic             w_blank;
  logic [7:0]       w_seg;

  assign w_divEnd   = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_frameEnd = w_divEnd && (r_idx == 3'd7);
  assign w_nibble   = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_top      = topNibble(r_shadow);
  assign w_blank    = blank_lz && (r_idx > w_top);

  hex_to_seg u_hexToSeg (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  // upd is delayed one extra stage so it lines up with the registered outputs
  // showing digit 0 of the new frame. A load on the boundary cycle is applied
  // after the transfer, so the transfer sees the old hold and pending stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_idx     <= '0;
      r_hold    <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_updPre  <= 1'b0;
      upd       <= 1'b0;
      led_en    <= 8'hFF;
      led_seg   <= SEG_BLANK;
    end else begin
      r_div    <= w_divEnd ? '0 : r_div + 1'b1;
      r_updPre <= 1'b0;
      if (w_divEnd) r_idx <= r_idx + 3'd1;
      if (w_frameEnd && r_pending) begin
        r_shadow  <= r_hold;
        r_pending <= 1'b0;
        r_updPre  <= 1'b1;
      end
      if (load) begin
        r_hold    <= result;
        r_pending <= 1'b1;
      end
      upd     <= r_updPre;
      led_en  <= ~(8'b1 << r_idx);
      led_seg <= w_seg;
    end
  end

endmodule

// File: tb/tb_hex_result_display.sv
// Directed self-checking bench for hex_result_display with SCAN_DIV = 4
// (one digit every 4 cycles, one frame every 32 cycles).
module tb_hex_result_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result;
  logic        load;
  logic        blank_lz;
  logic [7:0]  led_en;
  logic [7:0]  led_seg;
  logic        upd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  hex_result_display #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .result   (result),
    .load     (load),
    .blank_lz (blank_lz),
    .led_en   (led_en),
    .led_seg  (led_seg),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  // cyc counts edges since reset release; outputs after edge k show digit ((k-1)/4)%8
  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyLoad(input logic [31:0] value);
    result = value;
    load   = 1'b1;
    stepCycle();
    load   = 1'b0;
  endtask

  task automatic sampleFrame(output logic [255:0] enLog, output logic [255:0] segLog,
                             output logic [31:0] updLog);
    for (int s = 0; s < 32; s++) begin
      enLog[s*8 +: 8]  = led_en;
      segLog[s*8 +: 8] = led_seg;
      updLog[s]        = upd;
      stepCycle();
    end
  endtask

  task automatic waitUpd(input string name);
    int n;
    n = 0;
    while (upd !== 1'b1 && n < 40) begin
      stepCycle();
      n++;
    end
    checks++;
    if (upd !== 1'b1 || ((cyc - 1) % 32) != 0) begin
      errors++;
      $display("[TB] FAIL %s_upd_timing: upd=%b at cycle %0d, required upd=1 at frame start", name, upd, cyc);
    end
  endtask

  task automatic test_reset();
    logic [7:0] expEn;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checks++;
      if (led_en !== 8'hFF || led_seg !== 8'hFF || upd !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold: en=%h seg=%h upd=%b, required FF FF 0", led_en, led_seg, upd);
      end
    end
    rst = 1'b0;
    cyc = 0;
    stepCycle();
    checks++;
    if (led_en !== 8'hFE || led_seg !== 8'h03) begin
      errors++;
      $display("[TB] FAIL reset_first: en=%h seg=%h, required FE 03", led_en, led_seg);
    end
    for (int i = 0; i < 32; i++) begin
      stepCycle();
      expEn = ~(8'b1 << (((cyc - 1) / 4) % 8));
      checks++;
      if (led_en !== expEn || upd !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_scan: cycle %0d en=%h upd=%b, required %h 0", cyc, led_en, upd, expEn);
      end
    end
  endtask

  task automatic test_load_display();
    logic [255:0] enLog, segLog;
    logic [31:0]  updLog;
    logic [63:0]  expSegs;
    int d;
    int early;
    expSegs = 64'h9F250D9911C16385;
    blank_lz = 1'b0;
    stepCycle();
    stepCycle();
    applyLoad(32'h1234ABCD);
    early = 0;
    while (upd !== 1'b1 && early < 40) begin
      if (led_seg !== 8'h03) early++;
      stepCycle();
      early = (upd === 1'b1) ? early : early;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("[TB] FAIL load_early_change: %0d early segment changes, required 0", early);
    end
    waitUpd("load");
    sampleFrame(enLog, segLog, updLog);
    for (int s = 0; s < 32; s++) begin
      d = s / 4;
      checks++;
      if (enLog[s*8 +: 8] !== ~(8'b1 << d) || segLog[s*8 +: 8] !== expSegs[d*8 +: 8]
          || updLog[s] !== (s == 0)) begin
        errors++;
        $display("[TB] FAIL load_frame[%0d]: en=%h seg=%h upd=%b, required %h %h %b", s,
                 enLog[s*8 +: 8], segLog[s*8 +: 8], updLog[s], ~(8'b1 << d), expSegs[d*8 +: 8], s == 0);
      end
    end
  endtask

  task automatic test_blanking();
    logic [255:0] enLog, segLog;
    logic [31:0]  updLog;
    logic [63:0]  expSegs [2];
    logic [31:0]  values  [2];
    int d;
    values[0]  = 32'h0000_00F0;
    expSegs[0] = 64'hFFFFFFFFFFFF7103;
    values[1]  = 32'h0000_0000;
    expSegs[1] = 64'hFFFFFFFFFFFFFF03;
    blank_lz = 1'b1;
    for (int v = 0; v < 2; v++) begin
      applyLoad(values[v]);
      waitUpd("blank");
      sampleFrame(enLog, segLog, updLog);
      for (int s = 0; s < 32; s++) begin
        d = s / 4;
        checks++;
        if (enLog[s*8 +: 8] !== ~(8'b1 << d) || segLog[s*8 +: 8] !== expSegs[v][d*8 +: 8]
            || updLog[s] !== (s == 0)) begin
          errors++;
          $display("[TB] FAIL blank%0d_frame[%0d]: en=%h seg=%h upd=%b, required %h %h %b", v, s,
                   enLog[s*8 +: 8], segLog[s*8 +: 8], updLog[s], ~(8'b1 << d), expSegs[v][d*8 +: 8], s == 0);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_boundary_load();
    logic [255:0] enLog, segLog;
    logic [31:0]  updLog;
    logic [63:0]  expSegs [2];
    int d;
    expSegs[0] = 64'h1F4149990D259F03;
    expSegs[1] = 64'h010911C163856171;
    applyLoad(32'h7654_3210);
    while ((cyc % 32) != 31) stepCycle();
    applyLoad(32'h89AB_CDEF);
    stepCycle();
    for (int f = 0; f < 2; f++) begin
      sampleFrame(enLog, segLog, updLog);
      for (int s = 0; s < 32; s++) begin
        d = s / 4;
        checks++;
        if (enLog[s*8 +: 8] !== ~(8'b1 << d) || segLog[s*8 +: 8] !== expSegs[f][d*8 +: 8]
            || updLog[s] !== (s == 0)) begin
          errors++;
          $display("[TB] FAIL boundary%0d_frame[%0d]: en=%h seg=%h upd=%b, required %h %h %b", f, s,
                   enLog[s*8 +: 8], segLog[s*8 +: 8], updLog[s], ~(8'b1 << d), expSegs[f][d*8 +: 8], s == 0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] enLog, segLog;
    logic [31:0]  updLog;
    logic [63:0]  expSegs;
    int d;
    expSegs = 64'h030303030303030D;
    applyLoad(32'h1);
    applyLoad(32'h2);
    applyLoad(32'h3);
    waitUpd("b2b");
    for (int f = 0; f < 2; f++) begin
      sampleFrame(enLog, segLog, updLog);
      for (int s = 0; s < 32; s++) begin
        d = s / 4;
        checks++;
        if (enLog[s*8 +: 8] !== ~(8'b1 << d) || segLog[s*8 +: 8] !== expSegs[d*8 +: 8]
            || updLog[s] !== (s == 0 && f == 0)) begin
          errors++;
          $display("[TB] FAIL b2b%0d_frame[%0d]: en=%h seg=%h upd=%b, required %h %h %b", f, s,
                   enLog[s*8 +: 8], segLog[s*8 +: 8], updLog[s], ~(8'b1 << d), expSegs[d*8 +: 8],
                   s == 0 && f == 0);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    applyLoad(32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) stepCycle();
    rst = 1'b1;
    stepCycle();
    stepCycle();
    checks++;
    if (led_en !== 8'hFF || led_seg !== 8'hFF || upd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_hold: en=%h seg=%h upd=%b, required FF FF 0", led_en, led_seg, upd);
    end
    rst = 1'b0;
    cyc = 0;
    stepCycle();
    checks++;
    if (led_en !== 8'hFE || led_seg !== 8'h03 || upd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_first: en=%h seg=%h upd=%b, required FE 03 0", led_en, led_seg, upd);
    end
    for (int i = 0; i < 70; i++) begin
      stepCycle();
      checks++;
      if (led_seg !== 8'h03 || upd !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_discard: cycle %0d seg=%h upd=%b, required 03 0", cyc, led_seg, upd);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    result   = '0;
    blank_lz = 1'b0;
    test_reset();
    test_load_display();
    test_blanking();
    test_boundary_load();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_result_display.md
# hex_result_display

Eight-digit hexadecimal 7-segment scanner that shows the 32-bit calculator result on the board's multiplexed display. It sits downstream of the calculator core, consumes its `cal_result` word plus a load strobe, and drives the active-low digit enables and segment lines directly. Updates are frame-aligned, so a new value never appears partway through a scan sweep. Optional leading-zero blanking is provided.

## Interface
- `SCAN_DIV`, 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range ≥ 2.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `result` input 32: value to display; digit 7 = `result[31:28]`, digit 0 = `result[3:0]`.
- `load` input 1: single-cycle strobe; capture `result` for display.
- `blank_lz` input 1: 1 = blank leading zero digits; sampled every cycle.
- `led_en` output 8: digit enables, active-low; bit i = digit i.
- `led_seg` output 8: segments, active-low; bit 7..1 = a..g, bit 0 = dp (dp always off).
- `upd` output 1: one-cycle pulse when the displayed (shadow) value changes.

## Operation
- **Hold stage:** on `load`, `hold <= result` and `pending <= 1`.
- **Divider and index:**
  - Divider `div` counts 0..SCAN_DIV-1 and wraps.
  - When `div == SCAN_DIV-1`, `idx` (3 bits) increments and wraps from 7 to 0.
- **Frame boundary:** the cycle where `div == SCAN_DIV-1` and `idx == 7`.
  - If `pending` is set, `shadow <= hold`, `pending <= 0`, and `upd` pulses in the next cycle.
- **Simultaneous load and frame boundary:**
  - The transfer uses the pre-load `hold`.
  - `hold` takes the new `result`, and `pending` ends at 1, so the load wins.
  - The new value shows one frame later.
- **Multiple loads within a frame:** the last one wins. No queueing.
- **Leading-zero blanking:**
  - `top` = index of the highest nonzero nibble of `shadow`, or 0 if `shadow == 0`.
  - When `blank_lz == 1`, digits with index > `top` output segment code FF.
  - Digit 0 is always shown.
- **Output register:**
  - `led_en <= ~(8'b1 << idx)`.
  - `led_seg <= blanked ? 8'hFF : SEG[shadow nibble idx]`.
- **Reset values:**
  - Internal: `div = 0`, `idx = 0`, `hold = 0`, `shadow = 0`, `pending = 0`.
  - Outputs: `led_en = 8'hFF`, `led_seg = 8'hFF`, `upd = 0`.
- **Reset mid-frame:**
  - Any pending load is discarded.
  - The display returns to showing 0 on digit 0 in the first cycle after `rst` falls.

## Timing
- Output latency is 1 cycle from `idx`/`shadow` state to `led_en`/`led_seg`.
- First cycle after `rst` deasserts: `led_en = 8'hFE`, `led_seg = 8'h03` ("0").
- Each digit is enabled for exactly SCAN_DIV cycles. A full frame is 8·SCAN_DIV cycles.
- Display latency from `load`:
  - The new value appears at the start of the next frame.
  - Worst case is 8·SCAN_DIV cycles + 1.
- Exactly one digit enable is low at any time after reset. There are no glitches, because both outputs come from the same registered update.
- `upd` is high for exactly 1 cycle, coincident with the first `led_en = 8'hFE` of the new frame.

## Structure
- **Package `disp_pkg`:**
  - `DIGITS = 8` and `SEG_BLANK = 8'hFF`.
  - Segment table `SEG[0..F]`: 03, 9F, 25, 0D, 99, 49, 41, 1F, 01, 09, 11, C1, 63, 85, 61, 71.
- **Sub-module `hex_to_seg`:** combinational nibble plus blank flag → 8-bit segment code, reused by future display blocks.
- **Top level:** holds the divider, index, hold/shadow registers, blanking logic and the output register.

## Test plan
All scenarios use SCAN_DIV = 4.
- **Reset:** assert `rst` for 3 cycles, then release.
  - During reset: `led_en = FF`, `led_seg = FF`.
  - Next cycle: `led_en = FE`, `led_seg = 03`.
  - `led_en` shifts every 4 cycles: FE, FD, FB … 7F, FE.
- **Load and display:** `load` with `result = 32'h1234ABCD` mid-frame, `blank_lz = 0`.
  - Nothing changes until the frame boundary, then `upd` pulses.
  - Digits 0..7 show D, C, B, A, 4, 3, 2, 1, i.e. codes 85, 63, C1, 11, 99, 0D, 25, 9F.
- **Leading-zero blanking:** `result = 32'h0000_00F0`, `blank_lz = 1`.
  - Digit 0 = 03, digit 1 = 71, digits 2–7 = FF.
  - `result = 0`: only digit 0 is lit, showing 03.
- **Load at frame boundary:** A loaded earlier in the frame, then B loaded on the boundary cycle.
  - The frame shows A, the following frame shows B.
  - Two `upd` pulses, 32 cycles apart.
- **Back-to-back loads:** three loads in one frame (1, 2, 3).
  - Only 3 is displayed; a single `upd` pulse.
- **Reset mid-operation:** `rst` asserted mid-frame with a load pending.
  - After release, digit 0 shows 03, no `upd`, and the pending value is never displayed.
